// File: rtl/econ_latent_serializer.sv
// ============================================================================
//  Module      : econ_latent_serializer
//  Description : Buffers ECON encoder latent frames in a small circular frame
//                FIFO and streams them out one latent element per transfer
//                over a valid/ready interface with start/end-of-frame marks.
//                Frames arriving with no free slot are dropped and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module econ_latent_serializer #(
  parameter int N_LAT = 10,
  parameter int W_LAT = 22,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_LAT*W_LAT-1:0]   in_data,
  input  logic                     in_vld,
  output logic [W_LAT-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  output logic [7:0]               frame_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int IW = (N_LAT > 1) ? $clog2(N_LAT) : 1;

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_LAT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Frame storage; contents are only ever read after being written.
  logic [N_LAT-1:0][W_LAT-1:0] frame_mem [DEPTH];

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;

  logic            xfer;
  logic            last_xfer;
  logic            accept;
  logic            drop;

  // Next-state logic: transfer/accept decisions, pointers, counters and FSM.
  always_comb begin
    xfer      = (state_q == SEND) && out_ready;
    last_xfer = xfer && (idx_q == IDX_LAST);
    // A full buffer can still take a frame when the head frame leaves this cycle.
    accept    = in_vld && ((occ_q < OCC_FULL) || last_xfer);
    drop      = in_vld && !accept;

    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    idx_d       = idx_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    frame_cnt_d = frame_cnt_q;
    occ_d       = occ_q + OW'(accept) - OW'(last_xfer);

    if (accept) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    end

    if (xfer) begin
      idx_d = last_xfer ? '0 : idx_q + IW'(1);
    end

    if (last_xfer) begin
      rd_ptr_d    = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end

    case (state_q)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (last_xfer && (occ_d == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and status registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      idx_q       <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= 8'd0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      idx_q       <= idx_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Frame write port; no reset needed on the data array.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      frame_mem[wr_ptr_q] <= in_data;
    end
  end

  assign out_valid = (state_q == SEND);
  assign out_data  = frame_mem[rd_ptr_q][idx_q];
  assign out_sop   = out_valid && (idx_q == '0);
  assign out_eop   = out_valid && (idx_q == IDX_LAST);
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_econ_latent_serializer.sv
// ============================================================================
//  Module      : tb_econ_latent_serializer
//  Description : Directed self-checking bench for econ_latent_serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_econ_latent_serializer;

  localparam int N_LAT = 10;
  localparam int W_LAT = 22;
  localparam int DEPTH = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_LAT*W_LAT-1:0] in_data;
  logic                   in_vld;
  logic [W_LAT-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_sop;
  logic                   out_eop;
  logic                   overflow;
  logic [7:0]             drop_cnt;
  logic [7:0]             frame_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [W_LAT+2:0] got_w, exp_w;

  econ_latent_serializer #(.N_LAT(N_LAT), .W_LAT(W_LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_vld    (in_vld),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // Element k of the frame carries base+k+1.
  function automatic logic [N_LAT*W_LAT-1:0] mk_frame(input int base);
    logic [N_LAT*W_LAT-1:0] f;
    for (int k = 0; k < N_LAT; k++) f[k*W_LAT +: W_LAT] = W_LAT'(base + k + 1);
    return f;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_vld = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; in_vld = 1'b1; in_data = mk_frame(0); out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if ({out_valid, out_sop, out_eop} !== 3'b000) begin n_err++; $display("FAIL reset_outs: got %b want 000", {out_valid, out_sop, out_eop}); end
    n_vec++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_ovf: got ovf=%b drop=%0d want 0/0", overflow, drop_cnt); end
    n_vec++; if (frame_cnt !== 8'd0) begin n_err++; $display("FAIL reset_fcnt: got %0d want 0", frame_cnt); end
    reset = 1'b0; in_vld = 1'b0;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_vld_ignored: got %b want 0", out_valid); end
  endtask

  task automatic test_single_frame();
    @(negedge clk);
    in_data = mk_frame(0); in_vld = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    for (int k = 0; k < N_LAT; k++) begin
      got_w = {out_valid, out_sop, out_eop, out_data};
      exp_w = {1'b1, (k == 0), (k == N_LAT-1), W_LAT'(k + 1)};
      n_vec++; if (got_w !== exp_w) begin n_err++; $display("FAIL single_word%0d: got %h want %h", k, got_w, exp_w); end
      @(negedge clk);
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", out_valid); end
    n_vec++; if (frame_cnt !== 8'd1) begin n_err++; $display("FAIL single_fcnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_stall_toggle();
    int w;
    @(negedge clk);
    in_data = mk_frame(100); in_vld = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_vld = 1'b0;
    w = 0;
    for (int c = 0; c < 19; c++) begin
      got_w = {out_valid, out_sop, out_eop, out_data};
      exp_w = {1'b1, (w == 0), (w == N_LAT-1), W_LAT'(101 + w)};
      n_vec++; if (got_w !== exp_w) begin n_err++; $display("FAIL stall_cyc%0d: got %h want %h", c, got_w, exp_w); end
      out_ready = ((c % 2) == 0);
      if (out_ready) w++;
      @(negedge clk);
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_idle_after19: got %b want 0", out_valid); end
    n_vec++; if (frame_cnt !== 8'd2) begin n_err++; $display("FAIL stall_fcnt: got %0d want 2", frame_cnt); end
  endtask

  task automatic test_overflow();
    int base;
    @(negedge clk);
    out_ready = 1'b0; in_vld = 1'b1; in_data = mk_frame(200);
    @(negedge clk); in_data = mk_frame(300);
    @(negedge clk); in_data = mk_frame(400);
    @(negedge clk); in_vld = 1'b0;
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_vec++; if (drop_cnt !== 8'd1) begin n_err++; $display("FAIL ovf_drop: got %0d want 1", drop_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 2*N_LAT; i++) begin
      base = (i < N_LAT) ? 200 : 300;
      got_w = {out_valid, out_sop, out_eop, out_data};
      exp_w = {1'b1, ((i % N_LAT) == 0), ((i % N_LAT) == N_LAT-1), W_LAT'(base + (i % N_LAT) + 1)};
      n_vec++; if (got_w !== exp_w) begin n_err++; $display("FAIL ovf_word%0d: got %h want %h", i, got_w, exp_w); end
      @(negedge clk);
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_idle: got %b want 0", out_valid); end
    n_vec++; if (frame_cnt !== 8'd4) begin n_err++; $display("FAIL ovf_fcnt: got %0d want 4", frame_cnt); end
  endtask

  task automatic test_full_eop_push();
    int base;
    do_reset();
    @(negedge clk);
    out_ready = 1'b0; in_vld = 1'b1; in_data = mk_frame(500);
    @(negedge clk); in_data = mk_frame(600);
    @(negedge clk); in_vld = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3*N_LAT; i++) begin
      base = 500 + 100 * (i / N_LAT);
      got_w = {out_valid, out_sop, out_eop, out_data};
      exp_w = {1'b1, ((i % N_LAT) == 0), ((i % N_LAT) == N_LAT-1), W_LAT'(base + (i % N_LAT) + 1)};
      n_vec++; if (got_w !== exp_w) begin n_err++; $display("FAIL b2b_word%0d: got %h want %h", i, got_w, exp_w); end
      in_vld = (i == N_LAT-1);
      if (i == N_LAT-1) in_data = mk_frame(700);
      @(negedge clk);
    end
    in_vld = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b want 0", out_valid); end
    n_vec++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin n_err++; $display("FAIL b2b_no_ovf: got ovf=%b drop=%0d want 0/0", overflow, drop_cnt); end
    n_vec++; if (frame_cnt !== 8'd3) begin n_err++; $display("FAIL b2b_fcnt: got %0d want 3", frame_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    in_data = mk_frame(800); in_vld = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      got_w = {out_valid, out_sop, out_eop, out_data};
      exp_w = {1'b1, (i == 0), 1'b0, W_LAT'(801 + i)};
      n_vec++; if (got_w !== exp_w) begin n_err++; $display("FAIL midrst_word%0d: got %h want %h", i, got_w, exp_w); end
      if (i == 4) reset = 1'b1;
      @(negedge clk);
    end
    n_vec++; if ({out_valid, out_sop, out_eop} !== 3'b000) begin n_err++; $display("FAIL midrst_outs: got %b want 000", {out_valid, out_sop, out_eop}); end
    n_vec++; if (frame_cnt !== 8'd0 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin n_err++; $display("FAIL midrst_cnts: got fcnt=%0d drop=%0d ovf=%b want 0/0/0", frame_cnt, drop_cnt, overflow); end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_quiet%0d: got %b want 0", i, out_valid); end
    end
    in_data = mk_frame(900); in_vld = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    for (int k = 0; k < N_LAT; k++) begin
      got_w = {out_valid, out_sop, out_eop, out_data};
      exp_w = {1'b1, (k == 0), (k == N_LAT-1), W_LAT'(901 + k)};
      n_vec++; if (got_w !== exp_w) begin n_err++; $display("FAIL midrst_new%0d: got %h want %h", k, got_w, exp_w); end
      @(negedge clk);
    end
    n_vec++; if (frame_cnt !== 8'd1) begin n_err++; $display("FAIL midrst_fcnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_saturation();
    int sent, pushed, end_c;
    do_reset();
    @(negedge clk);
    out_ready = 1'b0; in_vld = 1'b1; in_data = mk_frame(1000);
    repeat (2 + 254) @(negedge clk);
    n_vec++; if (drop_cnt !== 8'd254) begin n_err++; $display("FAIL sat_drop254: got %0d want 254", drop_cnt); end
    repeat (46) @(negedge clk);
    in_vld = 1'b0;
    n_vec++; if (drop_cnt !== 8'd255 || overflow !== 1'b1) begin n_err++; $display("FAIL sat_drop300: got drop=%0d ovf=%b want 255/1", drop_cnt, overflow); end
    out_ready = 1'b1;
    sent = 0; pushed = 2; end_c = -1;
    for (int c = 0; c < 3000; c++) begin
      in_vld = 1'b0;
      if (out_valid && out_eop) begin
        sent++;
        if (pushed < 257) begin
          in_vld = 1'b1; in_data = mk_frame(pushed); pushed++;
        end
      end
      @(negedge clk);
      if (sent == 257) begin end_c = c; break; end
    end
    in_vld = 1'b0;
    n_vec++; if (end_c != 257*N_LAT - 1) begin n_err++; $display("FAIL sat_stream_cycles: got %0d want %0d", end_c, 257*N_LAT - 1); end
    n_vec++; if (frame_cnt !== 8'd1 || out_valid !== 1'b0) begin n_err++; $display("FAIL sat_fcnt_wrap: got fcnt=%0d vld=%b want 1/0", frame_cnt, out_valid); end
    n_vec++; if (drop_cnt !== 8'd255) begin n_err++; $display("FAIL sat_drop_hold: got %0d want 255", drop_cnt); end
  endtask

  initial begin
    reset = 1'b1; in_vld = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_single_frame();
    test_stall_toggle();
    test_overflow();
    test_full_eop_push();
    test_reset_mid_frame();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/econ_latent_serializer.md
ECON_LATENT_SERIALIZER -- requirements
Module: econ_latent_serializer

Interface
REQ-001 Parameter N_LAT, default 10: number of latent elements per encoder frame.
REQ-002 Parameter W_LAT, default 22: bit width of each latent element.
REQ-003 Parameter DEPTH, default 2: number of frames the buffer holds.
REQ-004 clk  in  1  clock; all logic SHALL be clocked on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_data  in  N_LAT*W_LAT (220)  latent frame from encoder layer5 output; element k occupies bits [k*W_LAT +: W_LAT].
REQ-007 in_vld  in  1  frame-valid qualifier; in_data is sampled on any cycle where it is high; there is no backpressure toward the encoder.
REQ-008 out_data  out  W_LAT  serialized latent word.
REQ-009 out_valid  out  1  out_data, out_sop and out_eop are valid.
REQ-010 out_ready  in  1  consumer accepts the word; a transfer occurs when out_valid && out_ready.
REQ-011 out_sop  out  1  high with element 0 of a frame.
REQ-012 out_eop  out  1  high with element N_LAT-1 of a frame.
REQ-013 overflow  out  1  sticky flag; set when any frame is dropped.
REQ-014 drop_cnt  out  8  count of dropped frames, saturating at 255.
REQ-015 frame_cnt  out  8  count of fully transmitted frames, wrapping at 256.

Function
REQ-016 The buffer SHALL be a DEPTH-entry circular frame FIFO with write pointer, read pointer and occupancy count 0..DEPTH.
REQ-017 A frame SHALL be accepted when in_vld=1 and either occupancy<DEPTH or the last word of the head frame transfers in the same cycle.
REQ-018 When in_vld=1 and neither acceptance condition holds, the frame SHALL be discarded, overflow SHALL be set and drop_cnt SHALL increment unless it is 255; stored frames SHALL remain unchanged.
REQ-019 The FSM SHALL have two states: IDLE (occupancy 0, out_valid=0) and SEND (out_valid=1).
REQ-020 IDLE->SEND SHALL occur on the edge that writes a frame, so out_valid rises one cycle after the accepted in_vld with word index 0.
REQ-021 In SEND, out_data SHALL be element idx of the head frame, with idx running 0..N_LAT-1; idx SHALL advance only on a transfer.
REQ-022 On a transfer at idx=N_LAT-1: the head frame SHALL be popped, idx SHALL go to 0, frame_cnt SHALL increment, and the state SHALL remain SEND if occupancy after the pop and push is >0, else go to IDLE.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_sop and out_eop SHALL stay constant.
REQ-024 out_sop SHALL equal (idx==0) and out_eop SHALL equal (idx==N_LAT-1), both gated by out_valid.
REQ-025 A simultaneous push and pop SHALL leave occupancy unchanged, and both pointers SHALL wrap modulo DEPTH.
REQ-026 Back-to-back frames with out_ready held high SHALL stream with no idle cycle between the eop of one frame and the sop of the next.

Reset
REQ-027 When reset=1, out_valid, out_sop, out_eop, overflow, drop_cnt, frame_cnt, occupancy, pointers and idx SHALL clear to 0 and the FSM SHALL enter IDLE on the next edge.
REQ-028 Reset during SEND SHALL abandon the partial frame; no further words of that frame SHALL be emitted.
REQ-029 in_vld SHALL be ignored while reset=1.
REQ-030 Frame buffer contents SHALL NOT require reset.

Verification
REQ-031 Single frame, in_data element k = k+1, out_ready=1 -> out_valid high on cycles t+1..t+10, data 1..10, sop on word 1, eop on word 10, frame_cnt=1.
REQ-032 out_ready toggling 1,0 per cycle -> 10 words delivered in order, each held stable through its stall cycles, 19 cycles total.
REQ-033 out_ready=0 with three in_vld pulses -> first two frames stored, third dropped, overflow=1, drop_cnt=1; after out_ready=1, 20 words out, frame_cnt=2.
REQ-034 Buffer full and a third in_vld on the eop-transfer cycle -> frame accepted, no overflow, 30 words stream contiguously.
REQ-035 Reset asserted at idx=4 -> out_valid=0 on the next cycle, all counters 0; a new frame afterwards is emitted from sop.
REQ-036 300 drops -> drop_cnt saturates at 255; 257 frames sent -> frame_cnt=1.
